// File: rtl/simple_alu_exec_pipe_pkg.sv
// Shared widths, opcode encodings and flag-bit positions for the execute-stage pipe
// and its ALU datapath.
package simple_alu_exec_pipe_pkg;

  localparam int SIZE_DATA       = 32;
  localparam int SIZE_IMMEDIATE  = 16;
  localparam int SIZE_OPCODE_I   = 8;
  localparam int EXECUTION_FLAGS = 3;
  localparam int SHAMT_W         = $clog2(SIZE_DATA);

  localparam int FLAG_EXECUTED   = 2;
  localparam int FLAG_EXCEPTION  = 1;
  localparam int FLAG_MISPREDICT = 0;

  localparam logic [SIZE_OPCODE_I-1:0] OP_ADD  = 8'h01;
  localparam logic [SIZE_OPCODE_I-1:0] OP_SUB  = 8'h02;
  localparam logic [SIZE_OPCODE_I-1:0] OP_AND  = 8'h03;
  localparam logic [SIZE_OPCODE_I-1:0] OP_OR   = 8'h04;
  localparam logic [SIZE_OPCODE_I-1:0] OP_XOR  = 8'h05;
  localparam logic [SIZE_OPCODE_I-1:0] OP_SLL  = 8'h06;
  localparam logic [SIZE_OPCODE_I-1:0] OP_SRL  = 8'h07;
  localparam logic [SIZE_OPCODE_I-1:0] OP_SRA  = 8'h08;
  localparam logic [SIZE_OPCODE_I-1:0] OP_ADDI = 8'h09;
  localparam logic [SIZE_OPCODE_I-1:0] OP_SLT  = 8'h0A;
  localparam logic [SIZE_OPCODE_I-1:0] OP_LUI  = 8'h0B;

  typedef struct packed {
    logic [SIZE_DATA-1:0]      data1;
    logic [SIZE_DATA-1:0]      data2;
    logic [SIZE_IMMEDIATE-1:0] immd;
    logic [SIZE_OPCODE_I-1:0]  opcode;
  } ex_pkt_t;

endpackage

// File: rtl/simple_alu_exec_pipe_alu.sv
// Combinational ALU datapath; undecoded opcodes yield zero result and zero flags.
// EXCEPTION flags signed overflow on the add/subtract family.
module simple_alu_exec_pipe_alu
  import simple_alu_exec_pipe_pkg::*;
(
  input  logic [SIZE_DATA-1:0]       data1,
  input  logic [SIZE_DATA-1:0]       data2,
  input  logic [SIZE_IMMEDIATE-1:0]  immd,
  input  logic [SIZE_OPCODE_I-1:0]   opcode,
  output logic [SIZE_DATA-1:0]       result,
  output logic [EXECUTION_FLAGS-1:0] flags
);

  logic [SIZE_DATA-1:0] and_bits, or_bits, xor_bits;
  logic [SIZE_DATA-1:0] imm_sext, sum, diff, sum_imm;
  logic                 sum_ovf, diff_ovf, sum_imm_ovf;

  for (genvar gi = 0; gi < SIZE_DATA; gi++) begin : g_logic
    assign and_bits[gi] = data1[gi] & data2[gi];
    assign or_bits[gi]  = data1[gi] | data2[gi];
    assign xor_bits[gi] = data1[gi] ^ data2[gi];
  end

  assign imm_sext = {{(SIZE_DATA-SIZE_IMMEDIATE){immd[SIZE_IMMEDIATE-1]}}, immd};
  assign sum      = data1 + data2;
  assign diff     = data1 - data2;
  assign sum_imm  = data1 + imm_sext;

  // Overflow: operand signs agree (add) or differ (sub) and the result sign flips.
  assign sum_ovf     = (data1[SIZE_DATA-1] == data2[SIZE_DATA-1]) && (sum[SIZE_DATA-1] != data1[SIZE_DATA-1]);
  assign diff_ovf    = (data1[SIZE_DATA-1] != data2[SIZE_DATA-1]) && (diff[SIZE_DATA-1] != data1[SIZE_DATA-1]);
  assign sum_imm_ovf = (data1[SIZE_DATA-1] == imm_sext[SIZE_DATA-1]) && (sum_imm[SIZE_DATA-1] != data1[SIZE_DATA-1]);

  always_comb begin
    result = '0;
    flags  = '0;
    flags[FLAG_EXECUTED] = 1'b1;
    case (opcode)
      OP_ADD:  begin result = sum;     flags[FLAG_EXCEPTION] = sum_ovf;     end
      OP_SUB:  begin result = diff;    flags[FLAG_EXCEPTION] = diff_ovf;    end
      OP_ADDI: begin result = sum_imm; flags[FLAG_EXCEPTION] = sum_imm_ovf; end
      OP_AND:  result = and_bits;
      OP_OR:   result = or_bits;
      OP_XOR:  result = xor_bits;
      OP_SLL:  result = data1 << data2[SHAMT_W-1:0];
      OP_SRL:  result = data1 >> data2[SHAMT_W-1:0];
      OP_SRA:  result = $unsigned($signed(data1) >>> data2[SHAMT_W-1:0]);
      OP_SLT:  result = {{(SIZE_DATA-1){1'b0}}, ($signed(data1) < $signed(data2))};
      OP_LUI:  result = {immd, {(SIZE_DATA-SIZE_IMMEDIATE){1'b0}}};
      default: flags = '0;
    endcase
  end

endmodule

// File: rtl/simple_alu_exec_pipe.sv
// Execute-stage wrapper: EX operand latch -> ALU -> WB result latch with valid/ready
// backpressure, flush, early bypass broadcast and a wrapping retired-op counter.
module simple_alu_exec_pipe
  import simple_alu_exec_pipe_pkg::*;
#(
  parameter int TAG_W = 7,
  parameter int ROB_W = 7,
  parameter int CNT_W = 16
)
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [SIZE_DATA-1:0]       in_data1_i,
  input  logic [SIZE_DATA-1:0]       in_data2_i,
  input  logic [SIZE_IMMEDIATE-1:0]  in_immd_i,
  input  logic [SIZE_OPCODE_I-1:0]   in_opcode_i,
  input  logic [TAG_W-1:0]           in_tag_i,
  input  logic [ROB_W-1:0]           in_rob_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [SIZE_DATA-1:0]       out_result_o,
  output logic [EXECUTION_FLAGS-1:0] out_flags_o,
  output logic [TAG_W-1:0]           out_tag_o,
  output logic [ROB_W-1:0]           out_rob_o,
  output logic                       byp_valid_o,
  output logic [TAG_W-1:0]           byp_tag_o,
  output logic [SIZE_DATA-1:0]       byp_data_o,
  output logic [CNT_W-1:0]           retired_cnt_o
);

  ex_pkt_t                    ex_pkt_reg;
  logic                       ex_valid_reg;
  logic [TAG_W-1:0]           ex_tag_reg;
  logic [ROB_W-1:0]           ex_rob_reg;
  logic                       wb_valid_reg;
  logic [SIZE_DATA-1:0]       wb_result_reg;
  logic [EXECUTION_FLAGS-1:0] wb_flags_reg;
  logic [TAG_W-1:0]           wb_tag_reg;
  logic [ROB_W-1:0]           wb_rob_reg;
  logic [CNT_W-1:0]           retired_cnt_reg, retired_cnt_next;

  logic [SIZE_DATA-1:0]       alu_result;
  logic [EXECUTION_FLAGS-1:0] alu_flags;
  logic                       wb_adv, ex_adv, wb_fire;

  assign wb_adv           = ex_valid_reg && (!wb_valid_reg || out_ready_i);
  assign in_ready_o       = !ex_valid_reg || wb_adv;
  assign ex_adv           = in_valid_i && in_ready_o;
  assign wb_fire          = wb_valid_reg && out_ready_i;
  assign retired_cnt_next = retired_cnt_reg + CNT_W'(1);

  simple_alu_exec_pipe_alu u_simple_alu (
    .data1  (ex_pkt_reg.data1),
    .data2  (ex_pkt_reg.data2),
    .immd   (ex_pkt_reg.immd),
    .opcode (ex_pkt_reg.opcode),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // EX may drain and reload in the same cycle, so the load test comes before the drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_reg <= 1'b0;
      ex_pkt_reg   <= '0;
      ex_tag_reg   <= '0;
      ex_rob_reg   <= '0;
    end else begin
      if (ex_adv) begin
        ex_pkt_reg <= '{data1: in_data1_i, data2: in_data2_i, immd: in_immd_i, opcode: in_opcode_i};
        ex_tag_reg <= in_tag_i;
        ex_rob_reg <= in_rob_i;
      end
      if (flush_i)     ex_valid_reg <= 1'b0;
      else if (ex_adv) ex_valid_reg <= 1'b1;
      else if (wb_adv) ex_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_reg  <= 1'b0;
      wb_result_reg <= '0;
      wb_flags_reg  <= '0;
      wb_tag_reg    <= '0;
      wb_rob_reg    <= '0;
    end else begin
      if (wb_adv) begin
        wb_result_reg <= alu_result;
        wb_flags_reg  <= alu_flags;
        wb_tag_reg    <= ex_tag_reg;
        wb_rob_reg    <= ex_rob_reg;
      end
      if (flush_i)          wb_valid_reg <= 1'b0;
      else if (wb_adv)      wb_valid_reg <= 1'b1;
      else if (out_ready_i) wb_valid_reg <= 1'b0;
    end
  end

  // A handshake in a flush cycle still completes, so the counter ignores flush_i.
  always_ff @(posedge clk) begin
    if (reset)        retired_cnt_reg <= '0;
    else if (wb_fire) retired_cnt_reg <= retired_cnt_next;
  end

  assign out_valid_o   = wb_valid_reg;
  assign out_result_o  = wb_result_reg;
  assign out_flags_o   = wb_flags_reg;
  assign out_tag_o     = wb_tag_reg;
  assign out_rob_o     = wb_rob_reg;
  assign retired_cnt_o = retired_cnt_reg;

  assign byp_valid_o = wb_adv && !flush_i && !reset;
  assign byp_tag_o   = ex_tag_reg;
  assign byp_data_o  = alu_result;

endmodule

// File: tb/tb_simple_alu_exec_pipe.sv
// Randomized scoreboard bench: issued ops are modelled with plain arithmetic and queued;
// a negedge monitor checks WB output, bypass, ready and the retired counter each cycle.
module tb_simple_alu_exec_pipe;
  import simple_alu_exec_pipe_pkg::*;

  localparam int TAG_W = 7;
  localparam int ROB_W = 7;
  localparam int CNT_W = 4;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       flush_i = 1'b0;
  logic                       in_valid_i = 1'b0;
  logic                       in_ready_o;
  logic [SIZE_DATA-1:0]       in_data1_i = '0;
  logic [SIZE_DATA-1:0]       in_data2_i = '0;
  logic [SIZE_IMMEDIATE-1:0]  in_immd_i = '0;
  logic [SIZE_OPCODE_I-1:0]   in_opcode_i = '0;
  logic [TAG_W-1:0]           in_tag_i = '0;
  logic [ROB_W-1:0]           in_rob_i = '0;
  logic                       out_valid_o;
  logic                       out_ready_i = 1'b1;
  logic [SIZE_DATA-1:0]       out_result_o;
  logic [EXECUTION_FLAGS-1:0] out_flags_o;
  logic [TAG_W-1:0]           out_tag_o;
  logic [ROB_W-1:0]           out_rob_o;
  logic                       byp_valid_o;
  logic [TAG_W-1:0]           byp_tag_o;
  logic [SIZE_DATA-1:0]       byp_data_o;
  logic [CNT_W-1:0]           retired_cnt_o;

  simple_alu_exec_pipe #(.TAG_W(TAG_W), .ROB_W(ROB_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data1_i(in_data1_i), .in_data2_i(in_data2_i), .in_immd_i(in_immd_i),
    .in_opcode_i(in_opcode_i), .in_tag_i(in_tag_i), .in_rob_i(in_rob_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_result_o(out_result_o), .out_flags_o(out_flags_o),
    .out_tag_o(out_tag_o), .out_rob_o(out_rob_o),
    .byp_valid_o(byp_valid_o), .byp_tag_o(byp_tag_o), .byp_data_o(byp_data_o),
    .retired_cnt_o(retired_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    logic [6:0]  tag;
    logic [6:0]  rob;
    int          vis;
    bit          shown;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   cnt_model = 0;
  int   ready_mode = 0;
  bit   prev_reset = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ALU: signed 64-bit arithmetic, overflow = result outside the 32-bit signed range.
  task automatic ref_alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] imm, output logic [31:0] res, output logic [2:0] flg);
    longint sa, sb, si, r;
    bit     ov;
    bit     known;
    sa = $signed(a);
    sb = $signed(b);
    si = $signed(imm);
    r = 0;
    ov = 1'b0;
    known = 1'b1;
    case (op)
      OP_ADD:  begin r = sa + sb; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      OP_SUB:  begin r = sa - sb; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      OP_ADDI: begin r = sa + si; ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      OP_AND:  r = longint'(a & b);
      OP_OR:   r = longint'(a | b);
      OP_XOR:  r = longint'(a ^ b);
      OP_SLL:  r = longint'(a << (b % 32));
      OP_SRL:  r = longint'(a >> (b % 32));
      OP_SRA:  r = sa >>> (b % 32);
      OP_SLT:  r = (sa < sb) ? 1 : 0;
      OP_LUI:  r = longint'(imm) * 65536;
      default: known = 1'b0;
    endcase
    res = known ? r[31:0] : 32'h0;
    flg = known ? {1'b1, ov, 1'b0} : 3'b000;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = 1'b0;
      default: out_ready_i = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Record every accepted packet with the cycle at which it should appear at WB.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #1;
    if (in_valid_i && in_ready_o && !flush_i && !reset) begin
      ref_alu(in_opcode_i, in_data1_i, in_data2_i, in_immd_i, e.res, e.flg);
      e.tag = in_tag_i;
      e.rob = in_rob_i;
      e.vis = cyc + 2;
      e.shown = 1'b0;
      q.push_back(e);
    end
  end

  initial forever begin
    bit hs, exp_v, exp_b;
    int bi, floor_c;
    @(negedge clk);
    if (reset) begin
      q.delete();
      cnt_model = 0;
      prev_reset = 1'b1;
    end else begin
      if (prev_reset) begin
        chk("rst_result", 64'(out_result_o), 64'h0);
        chk("rst_flags", 64'(out_flags_o), 64'h0);
        chk("rst_tag", 64'(out_tag_o), 64'h0);
        chk("rst_rob", 64'(out_rob_o), 64'h0);
      end
      prev_reset = 1'b0;
      hs = out_valid_o && out_ready_i;
      chk("in_ready", 64'(in_ready_o), 64'((q.size() < 2) || out_ready_i));
      exp_v = (q.size() > 0) && (q[0].vis <= cyc);
      chk("out_valid", 64'(out_valid_o), 64'(exp_v));
      if (exp_v && out_valid_o) begin
        chk("out_result", 64'(out_result_o), 64'(q[0].res));
        chk("out_flags", 64'(out_flags_o), 64'(q[0].flg));
        chk("out_tag", 64'(out_tag_o), 64'(q[0].tag));
        chk("out_rob", 64'(out_rob_o), 64'(q[0].rob));
        q[0].shown = 1'b1;
      end
      chk("retired_cnt", 64'(retired_cnt_o), 64'(cnt_model));
      if (hs) begin
        $display("retire tag=%0h rob=%0h result=%08h flags=%03b cnt_next=%0d",
                 out_tag_o, out_rob_o, out_result_o, out_flags_o, (cnt_model + 1) % 16);
        cnt_model = (cnt_model + 1) % 16;
        if (q.size() > 0) void'(q.pop_front());
      end
      floor_c = cyc + 1;
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].vis < floor_c) q[i].vis = floor_c;
        floor_c = q[i].vis + 1;
      end
      exp_b = 1'b0;
      bi = 0;
      for (int i = 0; i < q.size(); i++) begin
        if (!q[i].shown && q[i].vis == cyc + 1 && !flush_i) begin
          exp_b = 1'b1;
          bi = i;
        end
      end
      chk("byp_valid", 64'(byp_valid_o), 64'(exp_b));
      if (exp_b && byp_valid_o) begin
        chk("byp_tag", 64'(byp_tag_o), 64'(q[bi].tag));
        chk("byp_data", 64'(byp_data_o), 64'(q[bi].res));
      end
      if (flush_i) q.delete();
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] imm);
    bit acc;
    acc = 1'b0;
    in_valid_i = 1'b1;
    in_opcode_i = op;
    in_data1_i = a;
    in_data2_i = b;
    in_immd_i = imm;
    in_tag_i = 7'($urandom);
    in_rob_i = 7'($urandom);
    for (int w = 0; w < 50 && !acc; w++) begin
      @(negedge clk);
      #2;
      acc = in_ready_o && !flush_i && !reset;
      @(posedge clk);
      #1;
    end
    in_valid_i = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL issue_timeout: op=%0h not accepted, got in_ready=%0b expected 1", op, in_ready_o);
    end
  endtask

  initial begin
    logic [7:0] ops [11];
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_ADDI, OP_SLT, OP_LUI};

    step(3);
    reset = 1'b0;
    step(2);

    ready_mode = 0;
    issue(OP_ADD, 32'd5, 32'd7, 16'h0);
    step(4);

    // Backpressure: two ops fill the pipe, the third stalls until the consumer returns.
    ready_mode = 1;
    step(1);
    issue(OP_SUB, 32'd3, 32'd10, 16'h0);
    issue(OP_ADDI, 32'h7FFF_FFFF, 32'h0, 16'h0001);
    in_valid_i = 1'b1;
    in_opcode_i = OP_XOR;
    step(5);
    in_valid_i = 1'b0;
    ready_mode = 0;
    issue(OP_SRA, 32'h8000_0F00, 32'd4, 16'h0);
    issue(OP_LUI, 32'h0, 32'h0, 16'hBEEF);
    step(5);

    // Flush with EX and WB both occupied; the packet offered alongside is dropped.
    ready_mode = 1;
    step(1);
    issue(OP_OR, 32'h00F0, 32'h0F00, 16'h0);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 16'h0);
    flush_i = 1'b1;
    in_valid_i = 1'b1;
    in_opcode_i = OP_ADD;
    step(1);
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    step(3);

    // Reset in the middle of a stall.
    issue(OP_AND, 32'hF0F0, 32'hFF00, 16'h0);
    issue(OP_SLL, 32'h1, 32'd31, 16'h0);
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    ready_mode = 0;
    step(2);

    issue(8'hFF, 32'd123, 32'd456, 16'h7);
    step(4);

    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      in_valid_i = ($urandom_range(0, 3) != 0);
      in_opcode_i = ($urandom_range(0, 9) == 0) ? 8'($urandom) : ops[$urandom_range(0, 10)];
      in_data1_i = ($urandom_range(0, 4) == 0) ? 32'h7FFF_FFF0 : 32'($urandom);
      in_data2_i = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
      in_immd_i = 16'($urandom);
      in_tag_i = 7'($urandom);
      in_rob_i = 7'($urandom);
      flush_i = ($urandom_range(0, 24) == 0);
      step(1);
    end
    in_valid_i = 1'b0;
    flush_i = 1'b0;
    ready_mode = 0;
    step(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
